bus_arbiter: RTL
================

# bus_arbiter

Two-requester arbiter that shares the single 32-bit processor bus between the instruction fetch unit (read-only) and the execute unit (read/write). It sits between those units and the bus interface unit. Each requester sees a valid/ready request handshake, and the bus side uses one registered request per transaction. Execute has fixed priority, with a starvation guard for fetch and a per-transaction bus timeout.

## Interface
Parameters:
- DATA_BURST_LIMIT, 4: maximum consecutive execute grants while fetch is pending.
- TIMEOUT, 255: WAIT cycles without bus_ready before abort (8-bit counter, 1..255).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- fetch_vaild  in  1  fetch request; held until fetch_ready.
- fetch_address  in  32  fetch byte address, passed unmodified (requester aligns).
- fetch_ready  out  1  one-cycle completion pulse.
- fetch_data  out  32  read data, valid while fetch_ready = 1.
- fetch_error  out  1  pulses with fetch_ready on timeout.
- execute_vaild  in  1  execute request; held until execute_ready.
- execute_write  in  1  1 = write, 0 = read.
- execute_address  in  32  byte address.
- execute_write_data  in  32  write data.
- execute_byte_enable  in  4  byte lanes.
- execute_ready  out  1  one-cycle completion pulse.
- execute_data  out  32  read data (0 for writes), valid while execute_ready = 1.
- execute_error  out  1  pulses with execute_ready on timeout.
- bus_vaild  out  1  registered bus request.
- bus_write  out  1  bus direction.
- bus_address  out  32  bus address.
- bus_write_data  out  32  bus write data.
- bus_byte_enable  out  4  bus byte lanes; 4'b1111 for fetch.
- bus_ready  in  1  bus completion; sampled only in WAIT.
- bus_read_data  in  32  bus read data, sampled with bus_ready.
- busy  out  1  1 in any state other than IDLE.
- grant_owner  out  1  0 = fetch, 1 = execute; owner of the current transaction.

## Operation
- All outputs reset to 0. State resets to IDLE, and the streak and timeout counters reset to 0.
- States are IDLE, WAIT and DONE. The default branch goes to IDLE.
- **IDLE**: if any request is present, the arbiter picks a winner. On that edge it registers the bus_* fields from the winner, sets bus_vaild to 1 and grant_owner to the winner, clears the timeout counter, and moves to WAIT. With no request it stays in IDLE with bus_vaild = 0.
- **Priority**: execute wins. The exception is when fetch_vaild = 1 and streak = DATA_BURST_LIMIT; then fetch wins.
- **Streak counter** (3 bits, saturating at DATA_BURST_LIMIT):
  - An execute grant while fetch_vaild = 1 increments the streak.
  - An execute grant with fetch_vaild = 0 clears it.
  - A fetch grant clears it.
- **WAIT with bus_ready = 1**: the arbiter sets bus_vaild to 0 and drives the owner's data and ready outputs:
  - read: data = bus_read_data;
  - write: data = 0;
  - owner's ready = 1, error = 0.
  - It then moves to DONE.
- **WAIT with bus_ready = 0**: the timeout counter increments. When the counter equals TIMEOUT-1 on an edge, the arbiter:
  - sets bus_vaild to 0;
  - drives owner's ready = 1, error = 1, data = 0;
  - moves to DONE.
- **DONE**: ready, error and data return to 0 and the state returns to IDLE. Requests are not evaluated in DONE.
- bus_address, bus_write, bus_write_data and bus_byte_enable hold their values from grant until the next grant.
- Requester inputs are captured only at grant. Changes to them during WAIT have no effect. A requester that drops valid mid-transaction still receives its ready pulse.

## Timing
- Request high at edge N in IDLE → bus_vaild = 1 from N+1.
- bus_ready sampled high at edge M → ready pulse in cycle M+1, bus_vaild = 0 in cycle M+1, IDLE at M+2.
- Minimum spacing is 3 cycles per transaction. A new grant can occur at the edge after DONE.
- bus_ready high in the same edge that the timeout is reached: a normal completion, with no error.
- bus_ready high outside WAIT is ignored.
- Asynchronous reset during WAIT drops bus_vaild immediately. No ready pulse is issued for the aborted transaction.

## Test plan
- **Single fetch**: fetch_vaild = 1, fetch_address = 0x100; bus_ready one cycle after bus_vaild with bus_read_data = 0xDEADBEEF → bus_address = 0x100, bus_byte_enable = 4'hF; fetch_ready for one cycle with fetch_data = 0xDEADBEEF; IDLE after 4 cycles total.
- **Simultaneous requests**: fetch and execute (write 0x55AA55AA to 0x200, byte_enable = 4'h3) both raised → execute granted first with bus_write = 1 and execute_data = 0; fetch granted at the edge after DONE.
- **Starvation guard**: execute_vaild held continuously with fetch_vaild = 1, DATA_BURST_LIMIT = 4 → grant order E,E,E,E,F,E, and the streak returns to 0 after F.
- **Timeout**: bus_ready held 0 with TIMEOUT = 255 → bus_vaild drops and the owner's ready and error pulse after exactly 255 WAIT cycles, data = 0.
- **Ready coincident with timeout**: bus_ready = 1 on the timeout edge → ready = 1, error = 0, data = bus_read_data.
- **Reset mid-transaction**: assert reset during WAIT → all outputs 0 immediately. After release with no requests, no ready pulse occurs and bus_vaild stays 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the fetch/execute requesters, the arbiter and the bus interface unit.
// The arbiter connects through the master modport; the surrounding environment uses slave.
interface bus_arbiter_if;
    logic        fetch_vaild;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        fetch_error;

    logic        execute_vaild;
    logic        execute_write;
    logic [31:0] execute_address;
    logic [31:0] execute_write_data;
    logic [3:0]  execute_byte_enable;
    logic        execute_ready;
    logic [31:0] execute_data;
    logic        execute_error;

    logic        bus_vaild;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    logic        busy;
    logic        grant_owner;

    modport master (
        input  fetch_vaild, fetch_address,
        input  execute_vaild, execute_write, execute_address, execute_write_data, execute_byte_enable,
        input  bus_ready, bus_read_data,
        output fetch_ready, fetch_data, fetch_error,
        output execute_ready, execute_data, execute_error,
        output bus_vaild, bus_write, bus_address, bus_write_data, bus_byte_enable,
        output busy, grant_owner
    );

    modport slave (
        output fetch_vaild, fetch_address,
        output execute_vaild, execute_write, execute_address, execute_write_data, execute_byte_enable,
        output bus_ready, bus_read_data,
        input  fetch_ready, fetch_data, fetch_error,
        input  execute_ready, execute_data, execute_error,
        input  bus_vaild, bus_write, bus_address, bus_write_data, bus_byte_enable,
        input  busy, grant_owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Fixed-priority fetch/execute bus arbiter with a fetch starvation guard and a per-transaction
// bus timeout. One registered bus request per transaction: IDLE -> WAIT -> DONE -> IDLE.
module bus_arbiter #(
    parameter int DATA_BURST_LIMIT = 4,
    parameter int TIMEOUT          = 255
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.master bus_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] STREAK_MAX   = 3'(DATA_BURST_LIMIT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state,           w_state_next;
    logic [2:0]  r_streak,          w_streak_next;
    logic [7:0]  r_timer,           w_timer_next;
    logic        r_bus_vaild,       w_bus_vaild_next;
    logic        r_bus_write,       w_bus_write_next;
    logic [31:0] r_bus_address,     w_bus_address_next;
    logic [31:0] r_bus_write_data,  w_bus_write_data_next;
    logic [3:0]  r_bus_byte_enable, w_bus_byte_enable_next;
    logic        r_grant_owner,     w_grant_owner_next;
    logic        r_fetch_ready,     w_fetch_ready_next;
    logic        r_fetch_error,     w_fetch_error_next;
    logic [31:0] r_fetch_data,      w_fetch_data_next;
    logic        r_execute_ready,   w_execute_ready_next;
    logic        r_execute_error,   w_execute_error_next;
    logic [31:0] r_execute_data,    w_execute_data_next;
    logic        w_any_request;
    logic        w_fetch_wins;

    assign w_any_request = bus_if.fetch_vaild | bus_if.execute_vaild;
    // Fetch only overtakes a pending execute once execute has used up its burst allowance.
    assign w_fetch_wins  = bus_if.fetch_vaild & (~bus_if.execute_vaild | (r_streak == STREAK_MAX));

    always_comb begin
        // NOTE: every next value gets a default before the case so no path can infer a latch.
        w_state_next           = r_state;
        w_streak_next          = r_streak;
        w_timer_next           = r_timer;
        w_bus_vaild_next       = r_bus_vaild;
        w_bus_write_next       = r_bus_write;
        w_bus_address_next     = r_bus_address;
        w_bus_write_data_next  = r_bus_write_data;
        w_bus_byte_enable_next = r_bus_byte_enable;
        w_grant_owner_next     = r_grant_owner;
        w_fetch_ready_next     = 1'b0;
        w_fetch_error_next     = 1'b0;
        w_fetch_data_next      = '0;
        w_execute_ready_next   = 1'b0;
        w_execute_error_next   = 1'b0;
        w_execute_data_next    = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any_request) begin
                    w_bus_vaild_next = 1'b1;
                    w_timer_next     = '0;
                    w_state_next     = S_WAIT;
                    if (w_fetch_wins) begin
                        w_grant_owner_next     = 1'b0;
                        w_bus_write_next       = 1'b0;
                        w_bus_address_next     = bus_if.fetch_address;
                        w_bus_write_data_next  = '0;
                        w_bus_byte_enable_next = 4'hF;
                        w_streak_next          = '0;
                    end else begin
                        w_grant_owner_next     = 1'b1;
                        w_bus_write_next       = bus_if.execute_write;
                        w_bus_address_next     = bus_if.execute_address;
                        w_bus_write_data_next  = bus_if.execute_write_data;
                        w_bus_byte_enable_next = bus_if.execute_byte_enable;
                        if (!bus_if.fetch_vaild)
                            w_streak_next = '0;
                        else if (r_streak != STREAK_MAX)
                            w_streak_next = r_streak + 3'd1;
                    end
                end
            end

            S_WAIT: begin
                // A completion on the timeout edge wins over the abort.
                if (bus_if.bus_ready) begin
                    w_bus_vaild_next = 1'b0;
                    w_state_next     = S_DONE;
                    if (r_grant_owner) begin
                        w_execute_ready_next = 1'b1;
                        w_execute_data_next  = r_bus_write ? 32'd0 : bus_if.bus_read_data;
                    end else begin
                        w_fetch_ready_next = 1'b1;
                        w_fetch_data_next  = bus_if.bus_read_data;
                    end
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_bus_vaild_next = 1'b0;
                    w_state_next     = S_DONE;
                    if (r_grant_owner) begin
                        w_execute_ready_next = 1'b1;
                        w_execute_error_next = 1'b1;
                    end else begin
                        w_fetch_ready_next = 1'b1;
                        w_fetch_error_next = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end

            S_DONE: w_state_next = S_IDLE;

            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_streak          <= '0;
            r_timer           <= '0;
            r_bus_vaild       <= 1'b0;
            r_bus_write       <= 1'b0;
            r_bus_address     <= '0;
            r_bus_write_data  <= '0;
            r_bus_byte_enable <= '0;
            r_grant_owner     <= 1'b0;
            r_fetch_ready     <= 1'b0;
            r_fetch_error     <= 1'b0;
            r_fetch_data      <= '0;
            r_execute_ready   <= 1'b0;
            r_execute_error   <= 1'b0;
            r_execute_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            r_state           <= w_state_next;
            r_streak          <= w_streak_next;
            r_timer           <= w_timer_next;
            r_bus_vaild       <= w_bus_vaild_next;
            r_bus_write       <= w_bus_write_next;
            r_bus_address     <= w_bus_address_next;
            r_bus_write_data  <= w_bus_write_data_next;
            r_bus_byte_enable <= w_bus_byte_enable_next;
            r_grant_owner     <= w_grant_owner_next;
            r_fetch_ready     <= w_fetch_ready_next;
            r_fetch_error     <= w_fetch_error_next;
            r_fetch_data      <= w_fetch_data_next;
            r_execute_ready   <= w_execute_ready_next;
            r_execute_error   <= w_execute_error_next;
            r_execute_data    <= w_execute_data_next;
        end
    end

    assign bus_if.bus_vaild       = r_bus_vaild;
    assign bus_if.bus_write       = r_bus_write;
    assign bus_if.bus_address     = r_bus_address;
    assign bus_if.bus_write_data  = r_bus_write_data;
    assign bus_if.bus_byte_enable = r_bus_byte_enable;
    assign bus_if.grant_owner     = r_grant_owner;
    assign bus_if.fetch_ready     = r_fetch_ready;
    assign bus_if.fetch_error     = r_fetch_error;
    assign bus_if.fetch_data      = r_fetch_data;
    assign bus_if.execute_ready   = r_execute_ready;
    assign bus_if.execute_error   = r_execute_error;
    assign bus_if.execute_data    = r_execute_data;
    assign bus_if.busy            = (r_state != S_IDLE);

endmodule
